// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: types, widths and helpers shared by the instruction
// memory loader and its word assembler.
//   loader_state_t : loader FSM state encoding
//   LEN_W          : width of the header word count
//   HDR_BYTES      : number of header bytes preceding the payload
//   csum_update    : running XOR checksum step
//   word_addr      : byte address of a given word index
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_t;

    localparam int LEN_W     = 16;
    localparam int HDR_BYTES = 2;

    // XOR checksum accumulate step
    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Word-aligned byte address of word idx; wraps modulo 2^32
    function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                              input logic [LEN_W-1:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into a 32-bit word.
//   clk, rst     : clock, async active-high reset
//   clr_i        : discard any partial word
//   load_i       : a payload byte is accepted this cycle
//   lane_i       : byte lane (0 = least significant) of byte_i
//   byte_i       : payload byte
//   word_o       : packed word including the byte currently offered
//   word_done_o  : pulse when the byte in lane 3 is accepted
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [31:0] merged_s;

    // Insert the offered byte into its lane of the partial word
    always_comb begin
        merged_s = word_q;
        case (lane_i)
            2'd0:    merged_s[7:0]   = byte_i;
            2'd1:    merged_s[15:8]  = byte_i;
            2'd2:    merged_s[23:16] = byte_i;
            2'd3:    merged_s[31:24] = byte_i;
            default: merged_s        = word_q;
        endcase
    end

    // Next partial-word value: clear wins over load
    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = 32'd0;
        end else if (load_i) begin
            word_d = merged_s;
        end else begin
            word_d = word_q;
        end
    end

    // Partial word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= 32'd0;
        end else begin
            word_q <= word_d;
        end
    end

    // The full word is available combinationally with the 4th byte so the
    // top can register it in the same edge that accepts that byte.
    assign word_o      = merged_s;
    assign word_done_o = load_i && !clr_i && (lane_i == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Parses a 16-bit little-endian word count, assembles little-endian words,
// writes them to consecutive addresses and verifies a trailing XOR checksum.
// The CPU is held until a complete image with a good checksum is loaded.
//   clk, rst          : clock, async active-high reset
//   start             : pulse, begins (or restarts) a load
//   in_data/in_valid  : stream byte and its valid
//   in_ready          : loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data : registered instruction memory write port
//   busy, done, err   : load in progress / image good / sticky error
//   cpu_hold          : low only when a good image is loaded
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    loader_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic             in_ready_s;
    logic             hs_s;
    logic             asm_load_s;
    logic [31:0]      asm_word_s;
    logic             asm_done_s;
    logic [LEN_W-1:0] len_hdr_s;
    logic             len_bad_s;

    assign in_ready_s = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CSUM);
    assign hs_s       = in_valid && in_ready_s;

    // Full length as it becomes known while the high header byte is accepted
    assign len_hdr_s  = {in_data, len_q[7:0]};
    assign len_bad_s  = (len_hdr_s == {LEN_W{1'b0}}) ||
                        (int'(len_hdr_s) > MAX_WORDS);

    // A byte that coincides with start is dropped, so it never reaches lanes
    assign asm_load_s = hs_s && !start && (state_q == DATA);

    word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start),
        .load_i      (asm_load_s),
        .lane_i      (byte_idx_q),
        .byte_i      (in_data),
        .word_o      (asm_word_s),
        .word_done_o (asm_done_s)
    );

    // Next-state, counter, checksum and write-port logic
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (start) begin
            state_d    = LEN0;
            word_cnt_d = {LEN_W{1'b0}};
            byte_idx_d = 2'd0;
            csum_d     = 8'd0;
        end else if (hs_s) begin
            case (state_q)
                LEN0: begin
                    len_d[7:0] = in_data;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d      = len_hdr_s;
                    word_cnt_d = {LEN_W{1'b0}};
                    byte_idx_d = 2'd0;
                    csum_d     = 8'd0;
                    if (len_bad_s) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d     = csum_update(csum_q, in_data);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (asm_done_s) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_addr(BASE_ADDR, word_cnt_q);
                        wr_data_d  = asm_word_s;
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        if (word_cnt_q == (len_q - LEN_W'(1))) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                CSUM: begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= {LEN_W{1'b0}};
            word_cnt_q <= {LEN_W{1'b0}};
            byte_idx_q <= 2'd0;
            csum_q     <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Status outputs are pure decodes of the registered state
    assign in_ready = in_ready_s;
    assign busy     = in_ready_s;
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-image loads plus
// hand-written sequences for reset, restart, length boundary and async reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int tests = 0;
    int fails = 0;

    logic [63:0] wq[$];

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // Log every write-strobe cycle; a stretched strobe would log twice
    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
    end

    typedef struct packed {
        logic [95:0] stream;   // byte i at [8*i +: 8]
        int          n;
        bit          bp;
        bit          exp_done;
        int          nw;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vec[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is seen at the next rising edge
    task automatic do_start();
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte for one cycle; with bp an idle cycle precedes it
    task automatic feed(input logic [7:0] b, input bit bp);
        if (bp) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, in_ready, 32'd0);
        chk({tag, " wr_en"},    wr_en,    32'd0);
        chk({tag, " wr_addr"},  wr_addr,  32'd0);
        chk({tag, " wr_data"},  wr_data,  32'd0);
        chk({tag, " busy"},     busy,     32'd0);
        chk({tag, " done"},     done,     32'd0);
        chk({tag, " err"},      err,      32'd0);
        chk({tag, " cpu_hold"}, cpu_hold, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;

        // Payload 13 05 10 00 63 04 B5 00 XORs to 0xD4
        vec[0] = '{ {8'h00,8'hD4,8'h00,8'hB5,8'h04,8'h63,8'h00,8'h10,8'h05,8'h13,8'h00,8'h02},
                    11, 1'b0, 1'b1, 2, 32'h00100513, 32'h00B50463 };
        vec[1] = '{ {8'h00,8'h00,8'h00,8'hB5,8'h04,8'h63,8'h00,8'h10,8'h05,8'h13,8'h00,8'h02},
                    11, 1'b0, 1'b0, 2, 32'h00100513, 32'h00B50463 };
        vec[2] = '{ {8'h00,8'hC1,8'h00,8'hB5,8'h04,8'h63,8'h00,8'h10,8'h05,8'h13,8'h00,8'h02},
                    11, 1'b0, 1'b0, 2, 32'h00100513, 32'h00B50463 };
        vec[3] = '{ {80'h0, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 0, 32'h0, 32'h0 };
        vec[4] = '{ {80'h0, 8'h04, 8'h01}, 2, 1'b0, 1'b0, 0, 32'h0, 32'h0 };
        vec[5] = '{ {40'h0,8'h13,8'h00,8'h00,8'h00,8'h13,8'h00,8'h01},
                    7, 1'b1, 1'b1, 1, 32'h00000013, 32'h0 };
        vec[6] = '{ {8'h00,8'hD4,8'h00,8'hB5,8'h04,8'h63,8'h00,8'h10,8'h05,8'h13,8'h00,8'h02},
                    11, 1'b1, 1'b1, 2, 32'h00100513, 32'h00B50463 };

        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", in_ready, 32'd0);

        // Table of complete loads; status sampled one cycle after last byte
        for (int k = 0; k < 7; k++) begin
            wq.delete();
            do_start();
            chk($sformatf("v%0d len0 busy", k), busy, 32'd1);
            chk($sformatf("v%0d len0 err", k), err, 32'd0);
            for (int i = 0; i < vec[k].n; i++) feed(vec[k].stream[8*i +: 8], vec[k].bp);
            chk($sformatf("v%0d done", k),     done,     {31'd0, vec[k].exp_done});
            chk($sformatf("v%0d err", k),      err,      {31'd0, !vec[k].exp_done});
            chk($sformatf("v%0d cpu_hold", k), cpu_hold, {31'd0, !vec[k].exp_done});
            chk($sformatf("v%0d in_ready", k), in_ready, 32'd0);
            chk($sformatf("v%0d busy", k),     busy,     32'd0);
            chk($sformatf("v%0d nwrites", k),  wq.size(), vec[k].nw);
            if (vec[k].nw > 0 && wq.size() > 0) begin
                chk($sformatf("v%0d addr0", k), wq[0][63:32], 32'h0);
                chk($sformatf("v%0d data0", k), wq[0][31:0],  vec[k].d0);
            end
            if (vec[k].nw > 1 && wq.size() > 1) begin
                chk($sformatf("v%0d addr1", k), wq[1][63:32], 32'h4);
                chk($sformatf("v%0d data1", k), wq[1][31:0],  vec[k].d1);
            end
        end

        // Length exactly MAX_WORDS is accepted
        do_start();
        feed(8'h00, 1'b0);
        feed(8'h04, 1'b0);
        chk("len1024 in_ready", in_ready, 32'd1);
        chk("len1024 err", err, 32'd0);
        chk("len1024 busy", busy, 32'd1);

        // Async reset mid-DATA, wr_addr/wr_data still hold the last load
        wq.delete();
        do_start();
        feed(8'h01, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h13, 1'b0);
        feed(8'h00, 1'b0);
        chk("pre-rst busy", busy, 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("async nwrites", wq.size(), 32'd0);

        // Restart after two payload bytes; start with a coincident byte
        wq.delete();
        do_start();
        feed(8'h02, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h13, 1'b0);
        feed(8'h05, 1'b0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h10;
        chk("restart in_ready", in_ready, 32'd1);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("restart busy", busy, 32'd1);
        feed(8'h01, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h13, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h00, 1'b0);
        chk("restart pre-csum done", done, 32'd0);
        feed(8'h13, 1'b0);
        chk("restart done", done, 32'd1);
        chk("restart cpu_hold", cpu_hold, 32'd0);
        chk("restart nwrites", wq.size(), 32'd1);
        if (wq.size() > 0) begin
            chk("restart addr", wq[0][63:32], 32'h0);
            chk("restart data", wq[0][31:0],  32'h00000013);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
